mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter LAT, default 2: memory read latency in cycles, from the mem_en_o cycle to the cycle in which mem_rdata_i is valid; legal range 1..15.
REQ-002 Parameter STREAK, default 4: maximum consecutive data grants while a fetch is pending; legal range 1..15.
REQ-003 clk_i  in  1  sole clock; all state updates on the rising edge.
REQ-004 rst_i  in  1  asynchronous, active-low reset.
REQ-005 if_req_i  in  1  fetch request; held with if_addr_i stable until if_ack_o.
REQ-006 if_addr_i  in  32  fetch byte address.
REQ-007 if_rdata_o  out  32  fetched instruction word.
REQ-008 if_ack_o  out  1  one-cycle fetch completion pulse.
REQ-009 dm_req_i  in  1  data request; held with dm_we_i, dm_addr_i and dm_wdata_i stable until dm_ack_o.
REQ-010 dm_we_i  in  1  1 = write, 0 = read.
REQ-011 dm_addr_i  in  32  data byte address.
REQ-012 dm_wdata_i  in  32  store data.
REQ-013 dm_rdata_o  out  32  load data.
REQ-014 dm_ack_o  out  1  one-cycle data completion pulse.
REQ-015 mem_en_o  out  1  single-port memory access strobe.
REQ-016 mem_we_o  out  1  memory write strobe.
REQ-017 mem_addr_o  out  32  memory address.
REQ-018 mem_wdata_o  out  32  memory write data.
REQ-019 mem_rdata_i  in  32  memory read data.
REQ-020 busy_o  out  1  high in every non-IDLE state.

Function
REQ-021 The FSM SHALL have three states: IDLE, BUSY and ACK; all outputs SHALL be registered.
REQ-022 IDLE SHALL grant on the edge that samples any request and move to BUSY; with no request it SHALL stay in IDLE.
REQ-023 Priority SHALL go to data, except that fetch is granted when if_req_i=1 and the streak count equals STREAK.
REQ-024 The streak count (4 bits) SHALL increment, saturating, on a data grant with if_req_i=1; it SHALL clear on a fetch grant, or on a data grant with if_req_i=0.
REQ-025 On grant, the address, write data and type SHALL be latched; later changes on the request inputs SHALL be ignored until ACK.
REQ-026 mem_en_o, mem_addr_o, mem_wdata_o and mem_we_o (for data writes only) SHALL be driven in the first BUSY cycle only; at other times mem_en_o=0 and mem_we_o=0.
REQ-027 BUSY SHALL last exactly LAT+1 cycles, counted by a 4-bit counter, and then move to ACK.
REQ-028 On the last BUSY edge, mem_rdata_i SHALL load if_rdata_o (fetch) or dm_rdata_o (data read); a data write SHALL leave dm_rdata_o unchanged.
REQ-029 ACK SHALL last one cycle with exactly one of if_ack_o or dm_ack_o high; requests SHALL be ignored in ACK, and the next state SHALL be IDLE.
REQ-030 The requester SHALL drop its request, or present a new one, on the edge that ends the ACK cycle.
REQ-031 Latency SHALL be: request first high in cycle 0 with the arbiter in IDLE gives mem_en_o in cycle 1 and ack in cycle LAT+2; the minimum spacing between grants is LAT+3 cycles.
REQ-032 Simultaneous if_req_i and dm_req_i SHALL be resolved per REQ-023; the loser waits with no loss of its request.
REQ-033 if_ack_o and dm_ack_o SHALL never be high in the same cycle.

Reset
REQ-034 When rst_i=0, the state SHALL go to IDLE immediately (asynchronously), counters to 0, every output to 0 and the rdata registers to 0x00000000.
REQ-035 A reset asserted mid-BUSY SHALL abandon the access; no ack SHALL follow after reset is released.
REQ-036 The first grant after reset release SHALL be made on the first rising edge with rst_i=1 and a request present.

Verification (LAT=2, STREAK=4)
REQ-037 Fetch alone, if_addr_i=0x10, mem returns 0x00A00093 -> mem_en_o in cycle 1 with mem_addr_o=0x10; if_ack_o in cycle 4 with if_rdata_o=0x00A00093.
REQ-038 if_req_i and dm_req_i both raised in cycle 0, data read of 0x40 -> data granted first, dm_ack_o in cycle 4; fetch mem_en_o in cycle 6; if_ack_o in cycle 9.
REQ-039 Data write, addr 0x80, wdata 0xDEADBEEF -> mem_we_o=1 for one cycle only with matching address and data; dm_ack_o in cycle 4; dm_rdata_o unchanged.
REQ-040 dm_req_i held continuously and if_req_i held -> after 4 data grants the 5th grant goes to fetch, then data resumes.
REQ-041 rst_i pulled low in cycle 2 of a fetch -> busy_o=0 and all acks 0 immediately; no ack after release; a fresh fetch completes in LAT+2 cycles.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between an instruction-fetch
// port and a data port. Each access walks IDLE -> BUSY (LAT+1 cycles) -> ACK.
// Data normally wins arbitration. A waiting fetch is forced through after STREAK
// back-to-back data grants.
//
// Ports:
//   clk_i, rst_i                      clock, asynchronous active-low reset
//   if_req_i, if_addr_i               fetch request and byte address
//   if_rdata_o, if_ack_o              fetched word, one-cycle completion pulse
//   dm_req_i, dm_we_i, dm_addr_i,
//   dm_wdata_i                        data request, write flag, address, store data
//   dm_rdata_o, dm_ack_o              load data, one-cycle completion pulse
//   mem_en_o, mem_we_o, mem_addr_o,
//   mem_wdata_o, mem_rdata_i          single-port memory interface
//   busy_o                            high whenever the FSM is not idle
module mem_port_arbiter #(
    parameter int unsigned LAT    = 2,
    parameter int unsigned STREAK = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_rdata_o,
    output logic        if_ack_o,
    input  logic        dm_req_i,
    input  logic        dm_we_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_wdata_i,
    output logic [31:0] dm_rdata_o,
    output logic        dm_ack_o,
    output logic        mem_en_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    output logic        busy_o
);

    localparam logic [3:0] LatLast   = 4'(LAT);
    localparam logic [3:0] StreakMax = 4'(STREAK);

    typedef enum logic [1:0] {StIdle, StBusy, StAck} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  streak_q, streak_d;
    logic        fetch_q, fetch_d;    // type of the granted access: 1 = fetch
    logic        we_q, we_d;          // granted data access is a write
    logic        mem_en_q, mem_en_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        if_ack_q, if_ack_d;
    logic        dm_ack_q, dm_ack_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] dm_rdata_q, dm_rdata_d;
    logic        busy_q, busy_d;
    logic        grant_fetch;

    // Fetch wins only when data is absent or the data streak has hit its limit.
    assign grant_fetch = if_req_i && (!dm_req_i || streak_q == StreakMax);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        streak_d    = streak_q;
        fetch_d     = fetch_q;
        we_d        = we_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = 32'h0;
        mem_wdata_d = 32'h0;
        if_ack_d    = 1'b0;
        dm_ack_d    = 1'b0;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;

        unique case (state_q)
            StIdle: begin
                if (if_req_i || dm_req_i) begin
                    state_d  = StBusy;
                    cnt_d    = 4'd0;
                    mem_en_d = 1'b1;
                    if (grant_fetch) begin
                        fetch_d    = 1'b1;
                        we_d       = 1'b0;
                        mem_addr_d = if_addr_i;
                        streak_d   = 4'd0;
                    end else begin
                        fetch_d     = 1'b0;
                        we_d        = dm_we_i;
                        mem_we_d    = dm_we_i;
                        mem_addr_d  = dm_addr_i;
                        mem_wdata_d = dm_wdata_i;
                        // Only data grants that make a fetch wait extend the streak.
                        if (if_req_i) begin
                            streak_d = (streak_q == 4'hF) ? streak_q : streak_q + 4'd1;
                        end else begin
                            streak_d = 4'd0;
                        end
                    end
                end
            end
            StBusy: begin
                if (cnt_q == LatLast) begin
                    state_d = StAck;
                    if (fetch_q) begin
                        if_rdata_d = mem_rdata_i;
                        if_ack_d   = 1'b1;
                    end else begin
                        dm_ack_d = 1'b1;
                        if (!we_q) begin
                            dm_rdata_d = mem_rdata_i;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StAck: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            streak_q    <= 4'd0;
            fetch_q     <= 1'b0;
            we_q        <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            if_ack_q    <= 1'b0;
            dm_ack_q    <= 1'b0;
            if_rdata_q  <= 32'h0;
            dm_rdata_q  <= 32'h0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            streak_q    <= streak_d;
            fetch_q     <= fetch_d;
            we_q        <= we_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_ack_q    <= if_ack_d;
            dm_ack_q    <= dm_ack_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            busy_q      <= busy_d;
        end
    end

    assign if_rdata_o  = if_rdata_q;
    assign if_ack_o    = if_ack_q;
    assign dm_rdata_o  = dm_rdata_q;
    assign dm_ack_o    = dm_ack_q;
    assign mem_en_o    = mem_en_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter. A transaction-level reference model
// predicts each grant from the arbitration rules and derives output timing from
// the grant cycle: mem_en at +1, ack at +LAT+2, idle again at +LAT+3. A separate
// memory model answers whatever the DUT actually drives onto the memory port.
module tb_mem_port_arbiter;
    localparam int LAT    = 2;
    localparam int STREAK = 4;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_rdata_o;
    logic        if_ack_o;
    logic        dm_req_i;
    logic        dm_we_i;
    logic [31:0] dm_addr_i;
    logic [31:0] dm_wdata_i;
    logic [31:0] dm_rdata_o;
    logic        dm_ack_o;
    logic        mem_en_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;
    logic        busy_o;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .LAT    (LAT),
        .STREAK (STREAK)
    ) u_dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_rdata_o  (if_rdata_o),
        .if_ack_o    (if_ack_o),
        .dm_req_i    (dm_req_i),
        .dm_we_i     (dm_we_i),
        .dm_addr_i   (dm_addr_i),
        .dm_wdata_i  (dm_wdata_i),
        .dm_rdata_o  (dm_rdata_o),
        .dm_ack_o    (dm_ack_o),
        .mem_en_o    (mem_en_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .busy_o      (busy_o)
    );

    int n_checks = 0;
    int n_bad    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model state.
    int          cyc;
    bit          has_txn;
    int          g;              // cycle at whose end the current access was granted
    bit          t_fetch;
    bit          t_we;
    logic [31:0] t_addr;
    logic [31:0] t_wdata;
    logic [31:0] t_rdata;
    int          streak;
    logic [31:0] ref_mem [16];
    logic [31:0] exp_if_rdata;
    logic [31:0] exp_dm_rdata;
    int          n_fetch_grants;
    int          n_data_grants;

    // Requester state.
    bit if_pend;
    bit dm_pend;
    bit if_done;
    bit dm_done;

    // Environment memory driven by the DUT's actual memory port.
    logic [31:0] env_mem [16];
    bit          pipe_v [16];
    logic [31:0] pipe_d [16];

    task automatic step(input int pct);
        int d;
        bit idle;
        bit pick_fetch;
        @(posedge clk);
        #1;
        cyc++;
        d = has_txn ? cyc - g : 0;

        if (has_txn && d == LAT + 2 && !t_we) begin
            if (t_fetch) exp_if_rdata = t_rdata;
            else         exp_dm_rdata = t_rdata;
        end
        check("busy", 32'(busy_o), 32'(has_txn && d >= 1 && d <= LAT + 2));
        check("mem_en", 32'(mem_en_o), 32'(has_txn && d == 1));
        check("mem_we", 32'(mem_we_o), 32'(has_txn && d == 1 && t_we));
        if (has_txn && d == 1) begin
            check("mem_addr", mem_addr_o, t_addr);
            if (t_we) check("mem_wdata", mem_wdata_o, t_wdata);
        end
        check("if_ack", 32'(if_ack_o), 32'(has_txn && d == LAT + 2 && t_fetch));
        check("dm_ack", 32'(dm_ack_o), 32'(has_txn && d == LAT + 2 && !t_fetch));
        check("if_rdata", if_rdata_o, exp_if_rdata);
        check("dm_rdata", dm_rdata_o, exp_dm_rdata);

        // Memory: read data valid exactly LAT cycles after the strobe, junk otherwise.
        if (mem_en_o) begin
            if (mem_we_o) begin
                env_mem[mem_addr_o[5:2]] = mem_wdata_o;
            end else begin
                pipe_v[(cyc + LAT) % 16] = 1'b1;
                pipe_d[(cyc + LAT) % 16] = env_mem[mem_addr_o[5:2]];
            end
        end
        if (pipe_v[cyc % 16]) begin
            mem_rdata_i         = pipe_d[cyc % 16];
            pipe_v[cyc % 16]    = 1'b0;
        end else begin
            mem_rdata_i = $urandom;
        end

        // Requesters drop on the edge that ends their ack cycle.
        if (if_done) if_pend = 1'b0;
        if (dm_done) dm_pend = 1'b0;
        if_done = has_txn && d == LAT + 2 && t_fetch;
        dm_done = has_txn && d == LAT + 2 && !t_fetch;
        if (!if_pend && $urandom_range(99) < pct) begin
            if_pend   = 1'b1;
            if_addr_i = {26'h0, 4'($urandom), 2'b00};
        end
        if (!dm_pend && $urandom_range(99) < pct) begin
            dm_pend    = 1'b1;
            dm_we_i    = 1'($urandom_range(1));
            dm_addr_i  = {26'h0, 4'($urandom), 2'b00};
            dm_wdata_i = $urandom;
        end
        if_req_i = if_pend;
        dm_req_i = dm_pend;

        // Arbitration decided at the end of this cycle.
        idle = !has_txn || d >= LAT + 3;
        if (idle && (if_pend || dm_pend)) begin
            pick_fetch = if_pend && (!dm_pend || streak == STREAK);
            if (pick_fetch)   streak = 0;
            else if (if_pend) streak = (streak == 15) ? 15 : streak + 1;
            else              streak = 0;
            has_txn = 1'b1;
            g       = cyc;
            t_fetch = pick_fetch;
            if (pick_fetch) begin
                n_fetch_grants++;
                t_we    = 1'b0;
                t_addr  = if_addr_i;
                t_rdata = ref_mem[t_addr[5:2]];
            end else begin
                n_data_grants++;
                t_we    = dm_we_i;
                t_addr  = dm_addr_i;
                t_wdata = dm_wdata_i;
                if (t_we) ref_mem[t_addr[5:2]] = t_wdata;
                else      t_rdata = ref_mem[t_addr[5:2]];
            end
        end else if (idle) begin
            has_txn = 1'b0;
        end
    endtask

    task automatic reset_mid_fetch();
        int n;
        n = 0;
        while (((has_txn && (cyc - g) < LAT + 3) || if_pend || dm_pend) && n < 50) begin
            step(0);
            n++;
        end
        check("drain", 32'(n < 50), 32'd1);
        // Fetch raised for the next cycle; granted at its end.
        if_pend   = 1'b1;
        if_addr_i = 32'h10;
        step(0);
        step(0);
        step(0);
        #1;
        rst_i = 1'b0;
        #1;
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_if_ack", 32'(if_ack_o), 32'd0);
        check("rst_dm_ack", 32'(dm_ack_o), 32'd0);
        check("rst_mem_en", 32'(mem_en_o), 32'd0);
        check("rst_if_rdata", if_rdata_o, 32'h0);
        check("rst_dm_rdata", dm_rdata_o, 32'h0);
        has_txn      = 1'b0;
        streak       = 0;
        exp_if_rdata = 32'h0;
        exp_dm_rdata = 32'h0;
        if_pend      = 1'b0;
        dm_pend      = 1'b0;
        if_done      = 1'b0;
        dm_done      = 1'b0;
        if_req_i     = 1'b0;
        dm_req_i     = 1'b0;
        for (int i = 0; i < 16; i++) pipe_v[i] = 1'b0;
        @(negedge clk);
        rst_i = 1'b1;
    endtask

    initial begin
        int fetch_before;
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = $urandom;
            env_mem[i] = ref_mem[i];
            pipe_v[i]  = 1'b0;
            pipe_d[i]  = 32'h0;
        end
        cyc            = 0;
        has_txn        = 1'b0;
        g              = 0;
        streak         = 0;
        exp_if_rdata   = 32'h0;
        exp_dm_rdata   = 32'h0;
        n_fetch_grants = 0;
        n_data_grants  = 0;
        if_pend        = 1'b0;
        dm_pend        = 1'b0;
        if_done        = 1'b0;
        dm_done        = 1'b0;
        rst_i          = 1'b0;
        if_req_i       = 1'b0;
        if_addr_i      = 32'h0;
        dm_req_i       = 1'b0;
        dm_we_i        = 1'b0;
        dm_addr_i      = 32'h0;
        dm_wdata_i     = 32'h0;
        mem_rdata_i    = 32'h0;

        repeat (3) @(posedge clk);
        #1;
        check("init_busy", 32'(busy_o), 32'd0);
        check("init_mem_en", 32'(mem_en_o), 32'd0);
        check("init_mem_we", 32'(mem_we_o), 32'd0);
        check("init_if_ack", 32'(if_ack_o), 32'd0);
        check("init_dm_ack", 32'(dm_ack_o), 32'd0);
        check("init_if_rdata", if_rdata_o, 32'h0);
        check("init_dm_rdata", dm_rdata_o, 32'h0);
        @(negedge clk);
        rst_i = 1'b1;

        repeat (400) step(30);

        // Both ports always requesting: fetch must break through every STREAK+1 grants.
        fetch_before = n_fetch_grants;
        repeat (200) step(100);
        check("starve_guard", 32'(n_fetch_grants - fetch_before >= 200 / ((LAT + 3) * (STREAK + 1)) - 1),
              32'd1);

        reset_mid_fetch();
        repeat (400) step(50);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end
endmodule
